// File: rtl/i2s_frame_sched.sv
// Frame scheduler between the datapath and an I2S master serializer: TX/RX frame FIFOs,
// LRCLK-phased word presentation, prime/drain sequencing. Optional I2S_FRAME_SCHED_CNT_EN adds counters.
module i2s_frame_sched #(
  parameter int unsigned DSZ       = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PRIME_LVL = 2
) (
  input  logic                   i2s_bclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [DSZ-1:0]         tx_left,
  input  logic [DSZ-1:0]         tx_right,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic [DSZ-1:0]         rx_left,
  output logic [DSZ-1:0]         rx_right,
  input  logic                   i2s_lrclk,
  input  logic [DSZ-1:0]         left_data_out,
  input  logic [DSZ-1:0]         right_data_out,
  output logic [DSZ-1:0]         left_data_in,
  output logic [DSZ-1:0]         right_data_in,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic                   underrun,
  output logic                   overrun
`ifdef I2S_FRAME_SCHED_CNT_EN
  ,
  output logic [15:0]            underrun_cnt,
  output logic [15:0]            overrun_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned FW = 2 * DSZ;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           lrclk_q;
  logic           rise, fall;
  logic [FW-1:0]  tx_mem [DEPTH];
  logic [FW-1:0]  rx_mem [DEPTH];
  logic [LW-1:0]  tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
  logic           tx_empty, tx_full, tx_push, tx_pop, tx_flush, tx_go;
  logic           rx_empty, rx_full, rx_push, rx_pop, rx_cap, rx_drop;
  logic           underrun_d;
  logic [DSZ-1:0] left_q, right_q, pend_q;
  logic           underrun_q, overrun_q;

  assign rise = !lrclk_q && i2s_lrclk;
  assign fall = lrclk_q && !i2s_lrclk;

  assign tx_level = tx_wptr_q - tx_rptr_q;
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;
  // The RISE that leaves PRIME already carries the first buffered frame.
  assign tx_go    = (state_q == RUN) || (state_q == DRAIN) || ((state_q == PRIME) && (state_d == RUN));
  assign tx_pop   = rise && tx_go && !tx_empty;
  assign underrun_d = rise && (state_q == RUN) && tx_empty;

  assign rx_valid = !rx_empty;
  assign rx_pop   = rx_valid && rx_ready;
  assign rx_cap   = fall && (state_q != IDLE);
  assign rx_push  = rx_cap && (!rx_full || rx_pop);
  assign rx_drop  = rx_cap && rx_full && !rx_pop;

  assign rx_left       = rx_valid ? rx_mem[rx_rptr_q[AW-1:0]][FW-1:DSZ] : '0;
  assign rx_right      = rx_valid ? rx_mem[rx_rptr_q[AW-1:0]][DSZ-1:0]  : '0;
  assign left_data_in  = left_q;
  assign right_data_in = right_q;
  assign state         = state_q;
  assign underrun      = underrun_q;
  assign overrun       = overrun_q;

  // State register
  always_ff @(posedge i2s_bclk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    tx_flush = 1'b0;
    case (state_q)
      IDLE:  if (enable) state_d = PRIME;
      PRIME: begin
        if (!enable) begin
          state_d  = IDLE;
          tx_flush = 1'b1;
        end else if (rise && (tx_level >= LW'(PRIME_LVL))) begin
          state_d = RUN;
        end
      end
      RUN:   if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable)                state_d = RUN;
        else if (rise && tx_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO storage
  always_ff @(posedge i2s_bclk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= {tx_left, tx_right};
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= {left_data_out, right_data_out};
  end

  // FIFO pointers; a flush drops any same-cycle push
  always_ff @(posedge i2s_bclk) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
    end else begin
      if (tx_flush) begin
        tx_rptr_q <= tx_wptr_q;
      end else begin
        tx_wptr_q <= tx_wptr_q + LW'(tx_push);
        tx_rptr_q <= tx_rptr_q + LW'(tx_pop);
      end
      rx_wptr_q <= rx_wptr_q + LW'(rx_push);
      rx_rptr_q <= rx_rptr_q + LW'(rx_pop);
    end
  end

  // Word scheduling: left and pending right load on RISE, right released on FALL
  always_ff @(posedge i2s_bclk) begin
    if (reset) begin
      lrclk_q    <= 1'b1;
      left_q     <= '0;
      right_q    <= '0;
      pend_q     <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      lrclk_q    <= i2s_lrclk;
      underrun_q <= underrun_d;
      overrun_q  <= rx_drop;
      if (rise) begin
        if (tx_pop) begin
          left_q <= tx_mem[tx_rptr_q[AW-1:0]][FW-1:DSZ];
          pend_q <= tx_mem[tx_rptr_q[AW-1:0]][DSZ-1:0];
        end else begin
          left_q <= '0;
          pend_q <= '0;
        end
      end
      if (fall) right_q <= pend_q;
    end
  end

`ifdef I2S_FRAME_SCHED_CNT_EN
  logic [15:0] underrun_cnt_q, overrun_cnt_q;

  // Saturating event counters, cleared only by reset
  always_ff @(posedge i2s_bclk) begin
    if (reset) begin
      underrun_cnt_q <= '0;
      overrun_cnt_q  <= '0;
    end else begin
      if (underrun_d && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_q <= underrun_cnt_q + 16'd1;
      if (rx_drop && (overrun_cnt_q != 16'hFFFF))     overrun_cnt_q  <= overrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
  assign overrun_cnt  = overrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_frame_sched.sv
// Scoreboard bench for i2s_frame_sched: directed frames, TX/RX monitors pop expected queues.
module tb_i2s_frame_sched;

  localparam int unsigned DSZ       = 16;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned PRIME_LVL = 2;
  localparam int unsigned LW        = $clog2(DEPTH) + 1;

  logic           i2s_bclk = 1'b0;
  logic           reset, enable, tx_valid, tx_ready, rx_valid, rx_ready, i2s_lrclk;
  logic [DSZ-1:0] tx_left, tx_right, rx_left, rx_right;
  logic [DSZ-1:0] left_data_out, right_data_out, left_data_in, right_data_in;
  logic [1:0]     state;
  logic [LW-1:0]  tx_level;
  logic           underrun, overrun;
`ifdef I2S_FRAME_SCHED_CNT_EN
  logic [15:0]    underrun_cnt, overrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int und_seen = 0;
  int ov_seen = 0;
  logic [31:0] txq[$];
  logic [31:0] rxq[$];

  always #5 i2s_bclk = ~i2s_bclk;

  i2s_frame_sched #(.DSZ(DSZ), .DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)) dut (
    .i2s_bclk      (i2s_bclk),
    .reset         (reset),
    .enable        (enable),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_left       (tx_left),
    .tx_right      (tx_right),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_left       (rx_left),
    .rx_right      (rx_right),
    .i2s_lrclk     (i2s_lrclk),
    .left_data_out (left_data_out),
    .right_data_out(right_data_out),
    .left_data_in  (left_data_in),
    .right_data_in (right_data_in),
    .state         (state),
    .tx_level      (tx_level),
    .underrun      (underrun),
    .overrun       (overrun)
`ifdef I2S_FRAME_SCHED_CNT_EN
    ,
    .underrun_cnt  (underrun_cnt),
    .overrun_cnt   (overrun_cnt)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(negedge i2s_bclk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  task automatic tx_push(input logic [15:0] l, input logic [15:0] r);
    tx_valid = 1'b1;
    tx_left  = l;
    tx_right = r;
    txq.push_back({l, r});
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Wire frame is complete the cycle after FALL; zero frames are idle fill.
  task automatic tx_monitor();
    logic        lr_prev;
    logic        fall_now;
    logic [31:0] got;
    lr_prev = 1'b1;
    forever begin
      @(posedge i2s_bclk);
      fall_now = lr_prev && !i2s_lrclk;
      lr_prev  = reset ? 1'b1 : i2s_lrclk;
      #1;
      if (underrun) und_seen++;
      if (overrun)  ov_seen++;
      if (fall_now && !reset) begin
        got = {left_data_in, right_data_in};
        if ((left_data_in == '0) != (right_data_in == '0)) fail("tx_pairing", got);
        else if (got != '0) begin
          if (txq.size() == 0) fail("tx_unexpected", got);
          else chk("tx_frame", got, txq.pop_front());
        end
      end
    end
  endtask

  // Sample just before the edge at which a pop happens.
  task automatic rx_monitor();
    logic [31:0] got;
    forever begin
      @(negedge i2s_bclk);
      #4;
      if (rx_valid && rx_ready) begin
        got = {rx_left, rx_right};
        if (got != '0) begin
          if (rxq.size() == 0) fail("rx_unexpected", got);
          else chk("rx_frame", got, rxq.pop_front());
        end
      end
    end
  endtask

  task automatic run_tests();
    int u0;
    int o0;
    tick(3);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_left", 32'(left_data_in), 32'd0);
    chk("rst_right", 32'(right_data_in), 32'd0);
    chk("rst_level", 32'(tx_level), 32'd0);
    chk("rst_pulses", 32'({underrun, overrun}), 32'd0);
    chk("rst_rx_data", {rx_left, rx_right}, 32'd0);
    reset = 1'b0;

    // Enabled with no data: stays in PRIME, silent, no underrun
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i2s_lrclk = 1'b0; tick(4);
      i2s_lrclk = 1'b1; tick(4);
    end
    chk("prime_hold", 32'(state), 32'd1);
    chk("prime_silent", {left_data_in, right_data_in}, 32'd0);
    chk("prime_no_underrun", 32'(und_seen), 32'd0);

    // RX overrun: DEPTH+1 captures with the consumer stalled
    rx_ready = 1'b0;
    o0 = ov_seen;
    for (int i = 0; i < DEPTH + 1; i++) begin
      left_data_out  = 16'hA5A5;
      right_data_out = 16'h0100 + 16'(i);
      if (i < DEPTH) rxq.push_back({16'hA5A5, 16'h0100 + 16'(i)});
      i2s_lrclk = 1'b0; tick(2);
      i2s_lrclk = 1'b1; tick(2);
    end
    left_data_out  = '0;
    right_data_out = '0;
    tick(2);
    chk("rx_valid_full", 32'(rx_valid), 32'd1);
    chk("rx_overrun_once", 32'(ov_seen - o0), 32'd1);
    chk("rx_head", {rx_left, rx_right}, {16'hA5A5, 16'h0100});
    rx_ready = 1'b1;
    tick(DEPTH + 2);
    chk("rx_drained", 32'(rx_valid), 32'd0);
    chk("rx_all_popped", 32'(rxq.size()), 32'd0);

    // Prime with two frames, enter RUN
    tx_push(16'h1111, 16'h2222);
    tx_push(16'h3333, 16'h4444);
    chk("prime_level", 32'(tx_level), 32'd2);
    i2s_lrclk = 1'b0; tick(4);
    i2s_lrclk = 1'b1; tick(1);
    chk("run_entered", 32'(state), 32'd2);
    chk("run_left1", 32'(left_data_in), 32'h1111);
    chk("run_right_hold", 32'(right_data_in), 32'd0);
    chk("run_level", 32'(tx_level), 32'd1);
    tick(3);
    i2s_lrclk = 1'b0; tick(1);
    chk("run_right1", 32'(right_data_in), 32'h2222);
    tick(3);
    i2s_lrclk = 1'b1; tick(1);
    chk("run_left2", 32'(left_data_in), 32'h3333);
    tick(3);
    i2s_lrclk = 1'b0; tick(4);

    // Underrun on empty FIFO, then resume
    u0 = und_seen;
    i2s_lrclk = 1'b1; tick(1);
    chk("underrun_pulse", 32'(underrun), 32'd1);
    chk("underrun_left0", 32'(left_data_in), 32'd0);
    tick(1);
    chk("underrun_one_cycle", 32'(underrun), 32'd0);
    tick(2);
    i2s_lrclk = 1'b0; tick(1);
    chk("underrun_right0", 32'(right_data_in), 32'd0);
    tick(3);
    chk("underrun_count", 32'(und_seen - u0), 32'd1);
    chk("underrun_stays_run", 32'(state), 32'd2);
    tx_push(16'h5555, 16'h6666);
    i2s_lrclk = 1'b1; tick(1);
    chk("resume_left", 32'(left_data_in), 32'h5555);
    tick(3);
    i2s_lrclk = 1'b0; tick(4);

    // Drain three frames after enable drops
    tx_push(16'h7001, 16'h7002);
    tx_push(16'h7003, 16'h7004);
    tx_push(16'h7005, 16'h7006);
    enable = 1'b0;
    tick(1);
    chk("drain_entered", 32'(state), 32'd3);
    u0 = und_seen;
    for (int k = 1; k <= 4; k++) begin
      i2s_lrclk = 1'b1; tick(1);
      chk("drain_state", 32'(state), (k < 4) ? 32'd3 : 32'd0);
      tick(3);
      i2s_lrclk = 1'b0; tick(4);
    end
    chk("drain_no_underrun", 32'(und_seen - u0), 32'd0);
    chk("drain_all_sent", 32'(txq.size()), 32'd0);

    // Fill TX FIFO, blocked push, then push and pop together
    for (int i = 0; i < DEPTH; i++) tx_push(16'h8000 + 16'(2 * i), 16'h8001 + 16'(2 * i));
    chk("full_ready", 32'(tx_ready), 32'd0);
    chk("full_level", 32'(tx_level), 32'(DEPTH));
    tx_valid = 1'b1; tx_left = 16'hDEAD; tx_right = 16'hBEEF;
    tick(1);
    tx_valid = 1'b0;
    chk("full_blocked", 32'(tx_level), 32'(DEPTH));
    enable = 1'b1;
    tick(1);
    i2s_lrclk = 1'b1; tick(1);
    chk("full_run", 32'(state), 32'd2);
    chk("full_pop_level", 32'(tx_level), 32'(DEPTH - 1));
    chk("full_left", 32'(left_data_in), 32'h8000);
    tick(3);
    i2s_lrclk = 1'b0; tick(4);
    i2s_lrclk = 1'b1;
    tx_push(16'h9001, 16'h9002);
    chk("pushpop_level", 32'(tx_level), 32'(DEPTH - 1));
    chk("pushpop_left", 32'(left_data_in), 32'h8002);
    tick(3);
    i2s_lrclk = 1'b0; tick(4);
    enable = 1'b0;
    tick(1);
    for (int k = 0; k < DEPTH; k++) begin
      i2s_lrclk = 1'b1; tick(4);
      i2s_lrclk = 1'b0; tick(4);
    end
    chk("final_idle", 32'(state), 32'd0);
    chk("final_all_sent", 32'(txq.size()), 32'd0);
    chk("final_level", 32'(tx_level), 32'd0);
    tick(4);
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    tx_valid       = 1'b0;
    tx_left        = '0;
    tx_right       = '0;
    rx_ready       = 1'b1;
    i2s_lrclk      = 1'b1;
    left_data_out  = '0;
    right_data_out = '0;
    fork
      run_tests();
      tx_monitor();
      rx_monitor();
    join_any
    disable fork;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
